// File: rtl/conv_issue_seq.sv
// Issues CLR / MAC / RD custom-0 instructions to the convolution unit one at a time,
// feeding MAC operands from a small FIFO and returning the final accumulator value.
module conv_issue_seq #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  output logic             opcode_valid_o,
  output logic [31:0]      opcode_opcode_o,
  output logic [31:0]      opcode_pc_o,
  output logic             opcode_invalid_o,
  output logic [4:0]       opcode_rd_idx_o,
  output logic [4:0]       opcode_ra_idx_o,
  output logic [4:0]       opcode_rb_idx_o,
  output logic [31:0]      opcode_ra_operand_o,
  output logic [31:0]      opcode_rb_operand_o,
  input  logic             unit_busy_i,
  input  logic             unit_valid_i,
  input  logic [31:0]      unit_writeback_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] OP_CLR = 32'h00C5850B;
  localparam logic [31:0] OP_MAC = 32'h00C5950B;
  localparam logic [31:0] OP_RD  = 32'h00C5A50B;

  typedef enum logic [2:0] {
    IDLE, CLR_ISSUE, CLR_WAIT, MAC_ISSUE, MAC_WAIT, RD_ISSUE, RD_WAIT, RESP
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      pc_cnt;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // The unit's busy flag is informational only; control relies on its completion pulse.
  logic unused_busy;
  assign unused_busy = unit_busy_i;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = op_valid_i && !full;
  assign pop   = (state == MAC_ISSUE) && !empty;

  assign op_ready_o       = !full;
  assign cmd_ready_o      = (state == IDLE);
  assign busy_o           = (state != IDLE);
  assign opcode_invalid_o = 1'b0;
  assign opcode_rd_idx_o  = 5'd10;
  assign opcode_ra_idx_o  = 5'd11;
  assign opcode_rb_idx_o  = 5'd12;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_ptr] <= op_a_i;
      mem_b[wr_ptr] <= op_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= IDLE;
      remaining           <= '0;
      pc_cnt              <= '0;
      opcode_valid_o      <= 1'b0;
      opcode_opcode_o     <= '0;
      opcode_pc_o         <= '0;
      opcode_ra_operand_o <= '0;
      opcode_rb_operand_o <= '0;
      res_valid_o         <= 1'b0;
      res_data_o          <= '0;
    end else begin
      opcode_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            remaining <= cmd_len_i;
            state     <= CLR_ISSUE;
          end
        end
        CLR_ISSUE: begin
          opcode_valid_o      <= 1'b1;
          opcode_opcode_o     <= OP_CLR;
          opcode_ra_operand_o <= '0;
          opcode_rb_operand_o <= '0;
          opcode_pc_o         <= pc_cnt;
          pc_cnt              <= pc_cnt + 32'd4;
          state               <= CLR_WAIT;
        end
        CLR_WAIT, MAC_WAIT: begin
          if (unit_valid_i) state <= (remaining != '0) ? MAC_ISSUE : RD_ISSUE;
        end
        MAC_ISSUE: begin
          // Stall here with no strobe until an operand pair is available.
          if (!empty) begin
            opcode_valid_o      <= 1'b1;
            opcode_opcode_o     <= OP_MAC;
            opcode_ra_operand_o <= mem_a[rd_ptr];
            opcode_rb_operand_o <= mem_b[rd_ptr];
            opcode_pc_o         <= pc_cnt;
            pc_cnt              <= pc_cnt + 32'd4;
            remaining           <= remaining - 1'b1;
            state               <= MAC_WAIT;
          end
        end
        RD_ISSUE: begin
          opcode_valid_o      <= 1'b1;
          opcode_opcode_o     <= OP_RD;
          opcode_ra_operand_o <= '0;
          opcode_rb_operand_o <= '0;
          opcode_pc_o         <= pc_cnt;
          pc_cnt              <= pc_cnt + 32'd4;
          state               <= RD_WAIT;
        end
        RD_WAIT: begin
          if (unit_valid_i) begin
            res_data_o <= unit_writeback_i;
            state      <= RESP;
          end
        end
        RESP: begin
          if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= IDLE;
          end else begin
            res_valid_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
